// File: rtl/fmul_sched_if.sv
// Request, multiplier and response signals of the shared-fmul scheduler.
// The slave view is the scheduler; the master view is its environment.
interface fmul_sched_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_x1;
    logic [32*NREQ-1:0]   req_x2;
    logic [31:0]          mul_x1;
    logic [31:0]          mul_x2;
    logic [31:0]          mul_y;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [31:0]          resp_y;
    logic [IDW-1:0]       resp_id;
    logic                 busy;

    modport slave (
        input  req_valid, req_x1, req_x2, mul_y, resp_ready,
        output req_ready, mul_x1, mul_x2, resp_valid, resp_y, resp_id, busy
    );

    modport master (
        output req_valid, req_x1, req_x2, mul_y, resp_ready,
        input  req_ready, mul_x1, mul_x2, resp_valid, resp_y, resp_id, busy
    );
endinterface

// File: rtl/fmul_sched.sv
// Round-robin issue of NREQ requesters into one stall-free fmul pipeline.
// Owner tags ride alongside fmul; results land in a credit-protected FIFO.
module fmul_sched #(
    parameter int NREQ  = 2,
    parameter int IDW   = 1,
    parameter int LAT   = 3,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    fmul_sched_if.slave   bus
);
    localparam int SW = $clog2(NREQ);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [IDW-1:0]     rr_r;
    logic [LAT-1:0]     tag_v_r;
    logic [IDW-1:0]     tag_id_r [LAT];
    logic [CW-1:0]      inflight_r;
    logic [CW-1:0]      fifo_cnt_r;
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [31+IDW:0]    mem_r [DEPTH];

    logic [CW:0]        used_s;
    logic               can_issue_s;
    logic               gnt_found_s;
    logic [IDW-1:0]     gnt_id_s;
    logic               issue_s;
    logic               push_s;
    logic               pop_s;
    logic               resp_valid_s;
    logic [31:0]        mul_x1_s;
    logic [31:0]        mul_x2_s;

    // Credit: entries already in the FIFO plus ops still inside fmul.
    assign used_s = {1'b0, fifo_cnt_r} + {1'b0, inflight_r};

    // Issue permission; a pop this cycle only frees credit next cycle.
    always_comb begin
        if (rst) begin
            can_issue_s = 1'b0;
        end else begin
            can_issue_s = (used_s < DEPTH_W);
        end
    end

    // Round-robin search starting just after the last granted requester.
    always_comb begin : grant_search
        int             idx;
        logic [SW-1:0]  sel;
        gnt_found_s = 1'b0;
        gnt_id_s    = '0;
        idx         = 0;
        sel         = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx         = (int'(rr_r) + k) % NREQ;
            sel         = SW'(idx);
            gnt_id_s    = (!gnt_found_s && bus.req_valid[sel]) ? IDW'(idx) : gnt_id_s;
            gnt_found_s = gnt_found_s | bus.req_valid[sel];
        end
    end

    assign issue_s       = gnt_found_s && can_issue_s;
    assign push_s        = tag_v_r[LAT-1];
    assign resp_valid_s  = (fifo_cnt_r != CW'(0));
    assign pop_s         = resp_valid_s && bus.resp_ready;

    // Operand mux toward fmul; zero whenever nothing issues.
    always_comb begin
        mul_x1_s = 32'd0;
        mul_x2_s = 32'd0;
        for (int i = 0; i < NREQ; i++) begin
            mul_x1_s = (issue_s && gnt_id_s == IDW'(i)) ? bus.req_x1[32*i +: 32] : mul_x1_s;
            mul_x2_s = (issue_s && gnt_id_s == IDW'(i)) ? bus.req_x2[32*i +: 32] : mul_x2_s;
        end
    end

    // Control state: tag valids, arbitration pointer, credit and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_r       <= IDW'(NREQ - 1);
            tag_v_r    <= '0;
            inflight_r <= '0;
            fifo_cnt_r <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
        end else begin
            tag_v_r    <= {tag_v_r[LAT-2:0], issue_s};
            inflight_r <= inflight_r + CW'(issue_s) - CW'(push_s);
            fifo_cnt_r <= fifo_cnt_r + CW'(push_s) - CW'(pop_s);
            if (issue_s) begin
                rr_r <= gnt_id_s;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // Owner ids shift with fmul; only meaningful where the matching valid is set.
    always_ff @(posedge clk) begin
        tag_id_r[0] <= gnt_id_s;
        for (int i = 1; i < LAT; i++) begin
            tag_id_r[i] <= tag_id_r[i-1];
        end
    end

    // Result storage, written as the owning tag leaves the pipeline.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {bus.mul_y, tag_id_r[LAT-1]};
        end
    end

    assign bus.req_ready  = issue_s ? (NREQ'(1) << gnt_id_s) : '0;
    assign bus.mul_x1     = mul_x1_s;
    assign bus.mul_x2     = mul_x2_s;
    assign bus.resp_valid = resp_valid_s;
    assign bus.resp_y     = mem_r[rd_ptr_r][31+IDW:IDW];
    assign bus.resp_id    = mem_r[rd_ptr_r][IDW-1:0];
    assign bus.busy       = (inflight_r != CW'(0)) || resp_valid_s;

    fmul_sched_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .cnt  (fifo_cnt_r)
    );
endmodule

// Result FIFO must never be written while already full.
module fmul_sched_chk #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input logic          clk,
    input logic          rst,
    input logic          push,
    input logic [CW-1:0] cnt
);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && cnt == CW'(DEPTH)));
endmodule

// File: tb/tb_fmul_sched.sv
// Directed bench for fmul_sched with a behavioural 3-stage fmul stand-in.
module tb_fmul_sched;
    localparam logic [31:0] X2_R0 = 32'h40400000;   // 3.0
    localparam logic [31:0] X2_R1 = 32'h40A00000;   // 5.0

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fmul_sched_if #(.NREQ(2), .IDW(1)) bus ();

    fmul_sched #(.NREQ(2), .IDW(1), .LAT(3), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int           n_chk  = 0;
    int           n_pass = 0;
    logic [32:0]  exp_q [$];
    logic [32:0]  got;
    logic [32:0]  want;
    logic [1:0]   want_rdy;

    // Normal-numbers-only multiply, truncating; enough for exact test products.
    function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        int          e;
        logic        s;
        s = a[31] ^ b[31];
        m = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        else if (m[47]) return {s, 8'(e + 1), m[46:24]};
        else return {s, 8'(e), m[45:23]};
    endfunction

    logic [31:0] p1, p2, p3;
    always @(posedge clk) begin
        p1 <= fmul_ref(bus.mul_x1, bus.mul_x2);
        p2 <= p1;
        p3 <= p2;
    end
    assign bus.mul_y = p3;

    function automatic logic [31:0] op_x1(input int k);
        return {1'b0, 8'(127 + k), 23'd0};
    endfunction

    // 2^k * 3.0 for requester 0, 2^k * 5.0 for requester 1
    function automatic logic [31:0] exp_prod(input int k, input int r);
        if (r == 0) return {1'b0, 8'(128 + k), 23'h400000};
        else return {1'b0, 8'(129 + k), 23'h200000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input int k);
        bus.req_valid = v;
        bus.req_x1    = {op_x1(k), op_x1(k)};
        bus.req_x2    = {X2_R1, X2_R0};
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        drive(2'b00, 0);
        bus.resp_ready = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(2'b11, 1);
        bus.resp_ready = 1'b0;
        tick();
        tick();
        #1;
        n_chk++; if (bus.req_ready !== 2'b00) $display("FAIL rst_req_ready got=%b want=00", bus.req_ready); else n_pass++;
        n_chk++; if (bus.resp_valid !== 1'b0) $display("FAIL rst_resp_valid got=%b want=0", bus.resp_valid); else n_pass++;
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b want=0", bus.busy); else n_pass++;
        n_chk++; if (bus.mul_x1 !== 32'd0 || bus.mul_x2 !== 32'd0) $display("FAIL rst_mul_x got=%h/%h want=0/0", bus.mul_x1, bus.mul_x2); else n_pass++;
        tick();
        rst = 1'b0;
        drive(2'b00, 0);
        #1;
        n_chk++; if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) $display("FAIL post_rst_idle got=%b%b want=00", bus.busy, bus.resp_valid); else n_pass++;
    endtask

    task automatic test_single();
        for (int c = 0; c < 6; c++) begin
            tick();
            bus.resp_ready = 1'b1;
            if (c == 0) begin
                bus.req_valid = 2'b01;
                bus.req_x1    = {32'd0, 32'h3FC00000};
                bus.req_x2    = {32'd0, 32'h40000000};
            end else begin
                bus.req_valid = 2'b00;
            end
            #1;
            if (c == 0) begin
                n_chk++; if (bus.req_ready !== 2'b01) $display("FAIL single_ready got=%b want=01", bus.req_ready); else n_pass++;
                n_chk++; if (bus.mul_x1 !== 32'h3FC00000) $display("FAIL single_mul_x1 got=%h want=3fc00000", bus.mul_x1); else n_pass++;
            end
            if (c == 3) begin
                n_chk++; if (bus.resp_valid !== 1'b0) $display("FAIL single_early got=%b want=0", bus.resp_valid); else n_pass++;
            end
            if (c == 4) begin
                n_chk++; if (bus.resp_valid !== 1'b1) $display("FAIL single_valid got=%b want=1", bus.resp_valid); else n_pass++;
                n_chk++; if (bus.resp_y !== 32'h40400000) $display("FAIL single_y got=%h want=40400000", bus.resp_y); else n_pass++;
                n_chk++; if (bus.resp_id !== 1'b0) $display("FAIL single_id got=%b want=0", bus.resp_id); else n_pass++;
                n_chk++; if (bus.busy !== 1'b1) $display("FAIL single_busy got=%b want=1", bus.busy); else n_pass++;
            end
            if (c == 5) begin
                n_chk++; if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) $display("FAIL single_idle got=%b%b want=00", bus.busy, bus.resp_valid); else n_pass++;
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            tick();
            drive((c < 6) ? 2'b11 : 2'b00, c);
            bus.resp_ready = 1'b1;
            #1;
            if (c < 6) begin
                want_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
                n_chk++; if (bus.req_ready !== want_rdy) $display("FAIL rr_grant c=%0d got=%b want=%b", c, bus.req_ready, want_rdy); else n_pass++;
                exp_q.push_back({exp_prod(c, c % 2), 1'(c % 2)});
            end
            n_chk++; if (bus.resp_valid !== (c >= 4 && c <= 9)) $display("FAIL rr_valid c=%0d got=%b", c, bus.resp_valid); else n_pass++;
            if (bus.resp_valid && bus.resp_ready) begin
                got  = {bus.resp_y, bus.resp_id};
                want = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1FFFFFFFF;
                n_chk++; if (got !== want) $display("FAIL rr_resp c=%0d got=%h want=%h", c, got, want); else n_pass++;
            end
        end
        n_chk++; if (exp_q.size() != 0) $display("FAIL rr_missing got=%0d want=0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.resp_ready = 1'b0;
        for (int c = 0; c < 14; c++) begin
            tick();
            drive(2'b10, c);
            #1;
            want_rdy = (c < 8) ? 2'b10 : 2'b00;
            n_chk++; if (bus.req_ready !== want_rdy) $display("FAIL bp_credit c=%0d got=%b want=%b", c, bus.req_ready, want_rdy); else n_pass++;
            if (c < 8) exp_q.push_back({exp_prod(c, 1), 1'b1});
        end
        n_chk++; if (dut.fifo_cnt_r !== 4'd8) $display("FAIL bp_count got=%0d want=8", dut.fifo_cnt_r); else n_pass++;
        for (int c = 14; c < 35; c++) begin
            tick();
            bus.resp_ready = 1'b1;
            drive((c < 20) ? 2'b10 : 2'b00, c);
            #1;
            if (c < 20) begin
                want_rdy = (c == 14) ? 2'b00 : 2'b10;
                n_chk++; if (bus.req_ready !== want_rdy) $display("FAIL bp_resume c=%0d got=%b want=%b", c, bus.req_ready, want_rdy); else n_pass++;
                if (c >= 15) exp_q.push_back({exp_prod(c, 1), 1'b1});
            end
            if (bus.resp_valid && bus.resp_ready) begin
                got  = {bus.resp_y, bus.resp_id};
                want = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1FFFFFFFF;
                n_chk++; if (got !== want) $display("FAIL bp_resp c=%0d got=%h want=%h", c, got, want); else n_pass++;
            end
        end
        n_chk++; if (exp_q.size() != 0 || bus.busy !== 1'b0) $display("FAIL bp_drain got=%0d/%b want=0/0", exp_q.size(), bus.busy); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            tick();
            rst = (c == 3);
            drive((c <= 3 || c == 5) ? 2'b01 : 2'b00, c);
            bus.resp_ready = 1'b1;
            #1;
            if (c < 3 || c == 5) begin
                n_chk++; if (bus.req_ready !== 2'b01) $display("FAIL mid_issue c=%0d got=%b want=01", c, bus.req_ready); else n_pass++;
            end
            if (c == 3) begin
                n_chk++; if (bus.req_ready !== 2'b00 || bus.mul_x1 !== 32'd0) $display("FAIL mid_rst_block got=%b/%h want=00/0", bus.req_ready, bus.mul_x1); else n_pass++;
            end
            if (c == 4 || c == 10) begin
                n_chk++; if (bus.busy !== 1'b0) $display("FAIL mid_busy c=%0d got=%b want=0", c, bus.busy); else n_pass++;
            end
            n_chk++; if (bus.resp_valid !== (c == 9)) $display("FAIL mid_valid c=%0d got=%b", c, bus.resp_valid); else n_pass++;
            if (c == 9) begin
                n_chk++; if ({bus.resp_y, bus.resp_id} !== {exp_prod(5, 0), 1'b0}) $display("FAIL mid_resp got=%h/%b want=%h/0", bus.resp_y, bus.resp_id, exp_prod(5, 0)); else n_pass++;
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 28; c++) begin
            tick();
            drive((c < 20) ? 2'b11 : 2'b00, c);
            bus.resp_ready = 1'b1;
            #1;
            if (c < 20) begin
                want_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
                n_chk++; if (bus.req_ready !== want_rdy) $display("FAIL b2b_grant c=%0d got=%b want=%b", c, bus.req_ready, want_rdy); else n_pass++;
                exp_q.push_back({exp_prod(c, c % 2), 1'(c % 2)});
            end
            n_chk++; if (dut.fifo_cnt_r > 4'd1) $display("FAIL b2b_count c=%0d got=%0d want<=1", c, dut.fifo_cnt_r); else n_pass++;
            if (c >= 3 && c <= 19) begin
                n_chk++; if (dut.inflight_r !== 4'd3) $display("FAIL b2b_inflight c=%0d got=%0d want=3", c, dut.inflight_r); else n_pass++;
            end
            if (bus.resp_valid && bus.resp_ready) begin
                got  = {bus.resp_y, bus.resp_id};
                want = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1FFFFFFFF;
                n_chk++; if (got !== want) $display("FAIL b2b_resp c=%0d got=%h want=%h", c, got, want); else n_pass++;
            end
        end
        n_chk++; if (exp_q.size() != 0 || bus.busy !== 1'b0) $display("FAIL b2b_drain got=%0d/%b want=0/0", exp_q.size(), bus.busy); else n_pass++;
    endtask

    // Runs straight after test_back_to_back, whose last grant left rr at 1.
    task automatic test_idle_skip();
        for (int c = 0; c < 11; c++) begin
            tick();
            drive((c < 5) ? 2'b10 : 2'b00, c);
            bus.resp_ready = 1'b1;
            #1;
            if (c < 5) begin
                n_chk++; if (bus.req_ready !== 2'b10) $display("FAIL skip_grant c=%0d got=%b want=10", c, bus.req_ready); else n_pass++;
                exp_q.push_back({exp_prod(c, 1), 1'b1});
            end
            if (bus.resp_valid && bus.resp_ready) begin
                got  = {bus.resp_y, bus.resp_id};
                want = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1FFFFFFFF;
                n_chk++; if (got !== want) $display("FAIL skip_resp c=%0d got=%h want=%h", c, got, want); else n_pass++;
            end
        end
        n_chk++; if (exp_q.size() != 0) $display("FAIL skip_missing got=%0d want=0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 2'b00;
        bus.req_x1     = '0;
        bus.req_x2     = '0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        test_back_to_back();
        test_idle_skip();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout want=finish");
        $fatal(1);
    end
endmodule

// File: doc/fmul_sched.md
Name: fmul_sched

Overview:
Shares one 3-stage `fmul` pipeline among NREQ requesters, issuing at most one multiply per cycle under round-robin arbitration. `fmul` has no stall, valid or reset, so this block tracks each operation's owner in a tag shift register that runs in lockstep with `fmul`. Results are captured in a result FIFO, and issue is credit-limited so the FIFO never overflows. The block sits between the FPU request ports and the `fmul` instance; `fmul` itself is instantiated by the parent.

Parameters:
- NREQ, 2, number of requesters (≥2).
- IDW, 1, width of requester id; must satisfy 2**IDW ≥ NREQ.
- LAT, 3, `fmul` latency in clock edges from operand capture to valid `y`.
- DEPTH, 8, result FIFO entries (power of two); must be ≥ LAT+2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  per-requester operation request
- req_ready  out  NREQ  per-requester grant; accept when valid&ready
- req_x1  in  32*NREQ  operand 1, requester i at [32i+31:32i]
- req_x2  in  32*NREQ  operand 2, same packing
- mul_x1  out  32  to `fmul` x1
- mul_x2  out  32  to `fmul` x2
- mul_y  in  32  from `fmul` y
- resp_valid  out  1  FIFO head valid
- resp_ready  in  1  consumer accepts head
- resp_y  out  32  product at FIFO head
- resp_id  out  IDW  requester that issued the head operation
- busy  out  1  high if any operation is in flight or the FIFO is non-empty

Behaviour:
- One clock `clk`; reset `rst` is synchronous and active-high.
- Reset clears tag valids, the inflight counter, FIFO count and pointers, and sets `rr` to NREQ-1 so requester 0 wins first. During and after reset: `req_ready`=0, `resp_valid`=0, `busy`=0, `mul_x1`=`mul_x2`=0.
- Operations inside `fmul` when reset is asserted are discarded; their tags are cleared, so the garbage `mul_y` is never written.
- Credit: `can_issue` = (fifo_count + inflight < DEPTH) && !rst. A pop in the current cycle does not free credit until the next cycle.
- Arbitration (combinational): search requesters `rr`+1, `rr`+2, … (mod NREQ); the first with `req_valid` is granted.
  - `req_ready[g]` = `can_issue`; all other `req_ready` bits are 0.
  - `req_ready` must not depend on `req_valid` of the same requester except through the grant search.
- Issue: in a cycle with a grant, `mul_x1`/`mul_x2` = the granted requester's operands, otherwise 0.
  - At the clock edge: `tag_v[0]`<=1, `tag_id[0]`<=g, `rr`<=g, `inflight` += 1.
  - With no issue: `tag_v[0]`<=0 and `rr` holds.
- Tag pipeline: `tag_v`/`tag_id` form an LAT-entry shift register, shifting every cycle unconditionally.
  - When `tag_v[LAT-1]`=1, `mul_y` is valid in that cycle.
  - At the next edge, `{mul_y, tag_id[LAT-1]}` is pushed into the FIFO and `inflight` -= 1.
- Latency: an op accepted in cycle c is written at the end of cycle c+LAT and is visible as `resp_valid` in cycle c+LAT+1 if the FIFO was empty.
- Simultaneous issue and writeback in the same cycle: `inflight` is unchanged.
- FIFO: `resp_valid` = (count≠0); `resp_y`/`resp_id` come from the head entry (combinational read).
  - Pop when `resp_valid` && `resp_ready`.
  - Simultaneous push and pop: count unchanged. Pointers wrap mod DEPTH.
  - Overflow is impossible by credit; a push into a full FIFO is an assertion failure in simulation.
- Throughput: with `resp_ready` held at 1, one issue per cycle is sustained indefinitely (count ≤ 1, inflight ≤ LAT).
- Order: responses are returned strictly in issue order across all requesters.
- `busy` = (inflight≠0) || (count≠0).
- Signed zero/underflow semantics belong to `fmul`; this block passes `mul_y` through unmodified.

Test Plan:
- Single op: requester 0 sends x1=0x3FC00000, x2=0x40000000 in cycle 0. Expect `req_ready[0]`=1 in cycle 0, `resp_valid`=1 in cycle 4 with `resp_y`=0x40400000 and `resp_id`=0, and `busy` falling after the pop.
- Round-robin: both requesters hold `req_valid` for 6 cycles with `resp_ready`=1. Expect grants 0,1,0,1,0,1 with one issue per cycle, and `resp_id` sequence 0,1,0,1,0,1 starting in cycle 4.
- Backpressure: hold `resp_ready`=0 with requester 1 streaming. Expect exactly DEPTH=8 issues total, `req_ready` held low, and count=8 without overflow. Raise `resp_ready`; expect 8 in-order results, then issue resumes.
- Reset mid-flight: issue 3 ops in cycles 0-2 and assert `rst` in cycle 3. Expect no `resp_valid` ever for those ops and `busy`=0 after reset. A new op issued after reset returns correctly 4 cycles later with id 0.
- Simultaneous push/pop at steady state: stream 20 ops with `resp_ready`=1. Expect count to stay ≤1, `inflight`=3 in steady state, and all 20 products matching a reference model.
- Idle requester skip: only requester 1 is valid while `rr`=1. Expect requester 1 granted every cycle, with no bubble inserted for requester 0.
